// File: rtl/e_alloc_pkg.sv
// Shared types and helpers for the circular slot allocator.
// Group and flush-cycle counts are derived per instance with div_ceil.
package e_alloc_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int DEF_W       = 32;
    localparam int DEF_RADIX_N = 4;

    function automatic int div_ceil(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Explicit wrap so non-power-of-two pools never produce an out-of-range pointer.
    function automatic int ptr_inc(input int p, input int w);
        return (p == w - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/e_alloc_pick.sv
// Circular first-zero search over occ starting at ptr, built from RADIX_N-wide
// priority groups over the doubled occupancy word.
module e_alloc_pick
    import e_alloc_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int RADIX_N = DEF_RADIX_N
) (
    input  logic [W-1:0]         occ,
    input  logic [$clog2(W)-1:0] ptr,
    output logic [W-1:0]         onehot,
    output logic [$clog2(W)-1:0] idx,
    output logic                 any
);

    localparam int IW       = $clog2(W);
    localparam int PW       = $clog2(RADIX_N);
    localparam int GROUPS_N = div_ceil(2 * W, RADIX_N);
    localparam int GW       = GROUPS_N * RADIX_N;

    logic [GW-1:0]                word;
    logic [GROUPS_N-1:0]          grp_hit;
    logic [GROUPS_N-1:0][PW-1:0]  grp_pos;
    int                           pos;

    // Bits below ptr in the lower copy are forced busy; padding is busy too.
    always_comb begin
        word = '1;
        for (int i = 0; i < 2 * W; i++) begin
            word[i] = occ[i % W] | (i < int'(ptr));
        end
    end

    always_comb begin
        for (int g = 0; g < GROUPS_N; g++) begin
            grp_hit[g] = 1'b0;
            grp_pos[g] = '0;
            for (int b = RADIX_N - 1; b >= 0; b--) begin
                if (!word[g * RADIX_N + b]) begin
                    grp_hit[g] = 1'b1;
                    grp_pos[g] = PW'(b);
                end
            end
        end
    end

    always_comb begin
        pos = 0;
        for (int g = GROUPS_N - 1; g >= 0; g--) begin
            if (grp_hit[g]) begin
                pos = g * RADIX_N + int'(grp_pos[g]);
            end
        end
        if (pos >= W) begin
            pos = pos - W;
        end
        any = ~&occ;
        idx = IW'(pos);
        onehot = '0;
        for (int i = 0; i < W; i++) begin
            onehot[i] = any && (i == pos);
        end
    end

endmodule

// File: rtl/e_slot_alloc.sv
// Round-robin slot allocator: occupancy/pointer registers, RUN/FLUSH FSM,
// incremental count and sticky error flag around the e_alloc_pick search.
module e_slot_alloc
    import e_alloc_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int RADIX_N = DEF_RADIX_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_vld_i,
    output logic                   alloc_rdy_o,
    output logic [$clog2(W)-1:0]   alloc_id_o,
    input  logic                   free_vld_i,
    input  logic [$clog2(W)-1:0]   free_id_i,
    input  logic                   flush_i,
    output logic                   flush_busy_o,
    output logic [W-1:0]           occ_o,
    output logic [$clog2(W+1)-1:0] count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   err_o
);

    localparam int IW      = $clog2(W);
    localparam int CW      = $clog2(W + 1);
    localparam int N_FLUSH = div_ceil(W, RADIX_N);
    localparam int GCW     = $clog2(N_FLUSH + 1);

    state_t         state;
    logic [W-1:0]   occ;
    logic [IW-1:0]  ptr;
    logic [CW-1:0]  count;
    logic           err;
    logic [GCW-1:0] grp;

    logic [W-1:0]   pick_onehot;
    logic           pick_any;
    logic           alloc_fire;
    logic           free_hit;
    logic           free_bad;
    logic [W-1:0]   set_mask;
    logic [W-1:0]   free_mask;
    logic [W-1:0]   grp_mask;
    logic [CW-1:0]  grp_cnt;

    e_alloc_pick #(
        .W       (W),
        .RADIX_N (RADIX_N)
    ) u_pick (
        .occ    (occ),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (alloc_id_o),
        .any    (pick_any)
    );

    assign full_o       = (count == CW'(W));
    assign empty_o      = (count == '0);
    assign alloc_rdy_o  = (state == RUN) && !full_o && pick_any;
    assign flush_busy_o = (state == FLUSH);
    assign occ_o        = occ;
    assign count_o      = count;
    assign err_o        = err;

    // Out-of-range ids short-circuit before indexing occ.
    always_comb begin
        alloc_fire = alloc_vld_i && alloc_rdy_o;
        free_hit   = 1'b0;
        free_bad   = 1'b0;
        if ((state == RUN) && free_vld_i) begin
            if ((int'(free_id_i) < W) && occ[free_id_i]) begin
                free_hit = 1'b1;
            end else begin
                free_bad = 1'b1;
            end
        end
        set_mask = alloc_fire ? pick_onehot : '0;
        grp_cnt  = '0;
        for (int i = 0; i < W; i++) begin
            free_mask[i] = free_hit && (int'(free_id_i) == i);
            grp_mask[i]  = ((i / RADIX_N) == int'(grp));
            grp_cnt      = grp_cnt + CW'(occ[i] & grp_mask[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            occ   <= '0;
            ptr   <= '0;
            count <= '0;
            err   <= 1'b0;
            grp   <= '0;
        end else begin
            case (state)
                RUN: begin
                    occ   <= (occ | set_mask) & ~free_mask;
                    count <= count + CW'(alloc_fire) - CW'(free_hit);
                    if (alloc_fire) begin
                        ptr <= IW'(ptr_inc(int'(alloc_id_o), W));
                    end
                    if (free_bad) begin
                        err <= 1'b1;
                    end
                    if (flush_i) begin
                        state <= FLUSH;
                        grp   <= '0;
                    end
                end
                FLUSH: begin
                    occ   <= occ & ~grp_mask;
                    count <= count - grp_cnt;
                    if (int'(grp) == N_FLUSH - 1) begin
                        state <= RUN;
                        ptr   <= '0;
                        grp   <= '0;
                    end else begin
                        grp <= grp + GCW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_e_slot_alloc.sv
// Self-checking bench: W=8/RADIX_N=4 and W=6/RADIX_N=5 instances, directed
// scenarios plus randomized traffic against a behavioural slot-pool model.
module tb_e_slot_alloc;

    localparam int AW = 8, AR = 4, BW = 6, BR = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_av, a_fv, a_fl, a_rdy, a_busy, a_full, a_empty, a_err;
    logic [2:0] a_fid, a_id;
    logic [7:0] a_occ;
    logic [3:0] a_count;
    logic       b_av, b_fv, b_fl, b_rdy, b_busy, b_full, b_empty, b_err;
    logic [2:0] b_fid, b_id;
    logic [5:0] b_occ;
    logic [2:0] b_count;

    int checks = 0;
    int errors = 0;

    e_slot_alloc #(.W(AW), .RADIX_N(AR)) dut_a (
        .clk(clk), .rst(rst), .alloc_vld_i(a_av), .alloc_rdy_o(a_rdy), .alloc_id_o(a_id),
        .free_vld_i(a_fv), .free_id_i(a_fid), .flush_i(a_fl), .flush_busy_o(a_busy),
        .occ_o(a_occ), .count_o(a_count), .full_o(a_full), .empty_o(a_empty), .err_o(a_err)
    );

    e_slot_alloc #(.W(BW), .RADIX_N(BR)) dut_b (
        .clk(clk), .rst(rst), .alloc_vld_i(b_av), .alloc_rdy_o(b_rdy), .alloc_id_o(b_id),
        .free_vld_i(b_fv), .free_id_i(b_fid), .flush_i(b_fl), .flush_busy_o(b_busy),
        .occ_o(b_occ), .count_o(b_count), .full_o(b_full), .empty_o(b_empty), .err_o(b_err)
    );

    // Behavioural pool: a bit per slot, a rotating start point, flush progress.
    typedef struct {
        bit occ [8];
        int ptr;
        bit err;
        bit flush;
        int grp;
    } model_t;

    model_t ma, mb;

    function automatic model_t m_reset();
        model_t m;
        for (int i = 0; i < 8; i++) m.occ[i] = 1'b0;
        m.ptr = 0; m.err = 1'b0; m.flush = 1'b0; m.grp = 0;
        return m;
    endfunction

    function automatic int m_pick(input model_t m, input int w);
        for (int k = 0; k < w; k++) begin
            if (!m.occ[(m.ptr + k) % w]) return (m.ptr + k) % w;
        end
        return -1;
    endfunction

    function automatic int m_count(input model_t m, input int w);
        int c = 0;
        for (int i = 0; i < w; i++) c += int'(m.occ[i]);
        return c;
    endfunction

    function automatic logic [7:0] m_vec(input model_t m, input int w);
        logic [7:0] v = '0;
        for (int i = 0; i < w; i++) v[i] = m.occ[i];
        return v;
    endfunction

    function automatic model_t m_step(input model_t m, input int w, input int r,
                                      input bit av, input bit fv, input int fid, input bit fl);
        model_t n = m;
        int g;
        if (m.flush) begin
            for (int i = m.grp * r; i < w && i < (m.grp + 1) * r; i++) n.occ[i] = 1'b0;
            n.grp = m.grp + 1;
            if (n.grp * r >= w) begin n.flush = 1'b0; n.ptr = 0; end
        end else begin
            g = m_pick(m, w);
            if (av && g >= 0) begin n.occ[g] = 1'b1; n.ptr = (g + 1) % w; end
            if (fv) begin
                if (fid < w && m.occ[fid]) n.occ[fid] = 1'b0;
                else n.err = 1'b1;
            end
            if (fl) begin n.flush = 1'b1; n.grp = 0; end
        end
        return n;
    endfunction

    task automatic tick();
        model_t na, nb;
        if (rst) begin
            na = m_reset(); nb = m_reset();
        end else begin
            na = m_step(ma, AW, AR, a_av, a_fv, int'(a_fid), a_fl);
            nb = m_step(mb, BW, BR, b_av, b_fv, int'(b_fid), b_fl);
        end
        @(posedge clk); #1;
        ma = na; mb = nb;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy: got %0b expected 1", a_rdy); end
        checks++; if (a_id !== 3'd0) begin errors++; $display("[TB] FAIL reset_id: got %0d expected 0", a_id); end
        checks++; if (a_busy !== 1'b0 || a_full !== 1'b0 || a_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_flags: got busy=%0b full=%0b empty=%0b expected 0 0 1", a_busy, a_full, a_empty); end
        checks++; if (a_count !== 4'd0 || a_occ !== 8'h00 || a_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_state: got count=%0d occ=%h err=%0b expected 0 00 0", a_count, a_occ, a_err); end
        checks++; if (b_rdy !== 1'b1 || b_empty !== 1'b1 || b_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_b: got rdy=%0b empty=%0b count=%0d expected 1 1 0", b_rdy, b_empty, b_count); end
    endtask

    task automatic test_fill();
        a_av = 1'b1;
        for (int i = 0; i < AW; i++) begin
            checks++; if (a_rdy !== 1'b1 || a_id !== 3'(i)) begin errors++; $display("[TB] FAIL fill_grant: got rdy=%0b id=%0d expected 1 %0d", a_rdy, a_id, i); end
            tick();
        end
        a_av = 1'b0;
        checks++; if (a_full !== 1'b1 || a_rdy !== 1'b0 || a_count !== 4'd8) begin errors++; $display("[TB] FAIL fill_full: got full=%0b rdy=%0b count=%0d expected 1 0 8", a_full, a_rdy, a_count); end
    endtask

    task automatic test_free_order();
        a_fv = 1'b1; a_fid = 3'd2; tick();
        a_fid = 3'd5; tick();
        a_fv = 1'b0;
        checks++; if (a_count !== 4'd6 || a_rdy !== 1'b1 || a_id !== 3'd2) begin errors++; $display("[TB] FAIL free_order_first: got count=%0d rdy=%0b id=%0d expected 6 1 2", a_count, a_rdy, a_id); end
        a_av = 1'b1; tick();
        checks++; if (a_id !== 3'd5) begin errors++; $display("[TB] FAIL free_order_second: got id=%0d expected 5", a_id); end
        tick();
        a_av = 1'b0;
        checks++; if (a_full !== 1'b1 || a_count !== 4'd8) begin errors++; $display("[TB] FAIL free_order_refill: got full=%0b count=%0d expected 1 8", a_full, a_count); end
    endtask

    task automatic test_back_to_back();
        a_av = 1'b1; a_fv = 1'b1; a_fid = 3'd4;
        checks++; if (a_rdy !== 1'b0) begin errors++; $display("[TB] FAIL full_no_grant: got rdy=%0b expected 0", a_rdy); end
        tick();
        a_fv = 1'b0;
        checks++; if (a_count !== 4'd7 || a_rdy !== 1'b1 || a_id !== 3'd4) begin errors++; $display("[TB] FAIL full_free_reenable: got count=%0d rdy=%0b id=%0d expected 7 1 4", a_count, a_rdy, a_id); end
        tick();
        a_av = 1'b0;
        checks++; if (a_count !== 4'd8 || a_full !== 1'b1) begin errors++; $display("[TB] FAIL full_regrant: got count=%0d full=%0b expected 8 1", a_count, a_full); end
        a_fv = 1'b1; a_fid = 3'd4; tick();
        a_av = 1'b1; a_fid = 3'd1;
        checks++; if (a_id !== 3'd4) begin errors++; $display("[TB] FAIL simul_grant: got id=%0d expected 4", a_id); end
        tick();
        a_fv = 1'b0;
        checks++; if (a_count !== 4'd7 || a_occ !== 8'b1111_1101) begin errors++; $display("[TB] FAIL simul_count: got count=%0d occ=%b expected 7 11111101", a_count, a_occ); end
        checks++; if (a_id !== 3'd1) begin errors++; $display("[TB] FAIL simul_next: got id=%0d expected 1", a_id); end
        tick();
        a_av = 1'b0;
    endtask

    task automatic test_wrap();
        a_fv = 1'b1; a_fid = 3'd2; tick();
        a_fv = 1'b0; a_av = 1'b1; tick();
        a_av = 1'b0; a_fv = 1'b1; a_fid = 3'd0; tick();
        a_fv = 1'b0;
        checks++; if (a_occ !== 8'b1111_1110 || a_id !== 3'd0) begin errors++; $display("[TB] FAIL wrap_grant: got occ=%b id=%0d expected 11111110 0", a_occ, a_id); end
        a_av = 1'b1; tick();
        a_av = 1'b0;
        a_fv = 1'b1; a_fid = 3'd0; tick();
        a_fid = 3'd5; tick();
        a_fv = 1'b0;
        checks++; if (a_id !== 3'd5) begin errors++; $display("[TB] FAIL wrap_ptr: got id=%0d expected 5", a_id); end
    endtask

    task automatic test_err();
        a_fv = 1'b1; a_fid = 3'd3; tick();
        checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL err_legal_free: got %0b expected 0", a_err); end
        tick();
        a_fv = 1'b0;
        checks++; if (a_err !== 1'b1 || a_count !== 4'd5) begin errors++; $display("[TB] FAIL err_double_free: got err=%0b count=%0d expected 1 5", a_err, a_count); end
        tick(); tick();
        checks++; if (a_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %0b expected 1", a_err); end
    endtask

    task automatic test_flush();
        a_av = 1'b1; a_fl = 1'b1;
        checks++; if (a_id !== 3'd3) begin errors++; $display("[TB] FAIL flush_entry_grant: got id=%0d expected 3", a_id); end
        tick();
        a_fl = 1'b0; a_fv = 1'b1; a_fid = 3'd6;
        checks++; if (a_busy !== 1'b1 || a_rdy !== 1'b0 || a_count !== 4'd6 || a_occ !== 8'b1101_1110) begin errors++; $display("[TB] FAIL flush_c0: got busy=%0b rdy=%0b count=%0d occ=%b expected 1 0 6 11011110", a_busy, a_rdy, a_count, a_occ); end
        tick();
        a_fv = 1'b0; a_av = 1'b0;
        checks++; if (a_busy !== 1'b1 || a_count !== 4'd3 || a_occ !== 8'b1101_0000) begin errors++; $display("[TB] FAIL flush_c1: got busy=%0b count=%0d occ=%b expected 1 3 11010000", a_busy, a_count, a_occ); end
        tick();
        checks++; if (a_busy !== 1'b0 || a_occ !== 8'h00 || a_count !== 4'd0 || a_rdy !== 1'b1 || a_id !== 3'd0 || a_err !== 1'b1) begin errors++; $display("[TB] FAIL flush_exit: got busy=%0b occ=%h count=%0d rdy=%0b id=%0d err=%0b expected 0 00 0 1 0 1", a_busy, a_occ, a_count, a_rdy, a_id, a_err); end
    endtask

    task automatic test_nonpow2();
        b_av = 1'b1;
        for (int i = 0; i < BW; i++) begin
            checks++; if (b_id !== 3'(i)) begin errors++; $display("[TB] FAIL b_fill: got id=%0d expected %0d", b_id, i); end
            tick();
        end
        b_av = 1'b0;
        checks++; if (b_full !== 1'b1 || b_rdy !== 1'b0 || b_count !== 3'd6) begin errors++; $display("[TB] FAIL b_full: got full=%0b rdy=%0b count=%0d expected 1 0 6", b_full, b_rdy, b_count); end
        b_fv = 1'b1; b_fid = 3'd4; tick();
        b_fv = 1'b0; b_av = 1'b1; tick();
        b_av = 1'b0; b_fv = 1'b1; b_fid = 3'd0; tick();
        b_fv = 1'b0;
        checks++; if (b_rdy !== 1'b1 || b_id !== 3'd0) begin errors++; $display("[TB] FAIL b_wrap: got rdy=%0b id=%0d expected 1 0", b_rdy, b_id); end
        b_av = 1'b1; tick();
        b_av = 1'b0;
        b_fl = 1'b1; b_fv = 1'b1; b_fid = 3'd2; tick();
        b_fl = 1'b0; b_fv = 1'b1; b_fid = 3'd0;
        checks++; if (b_busy !== 1'b1 || b_count !== 3'd5 || b_occ !== 6'b111011) begin errors++; $display("[TB] FAIL b_flush_entry: got busy=%0b count=%0d occ=%b expected 1 5 111011", b_busy, b_count, b_occ); end
        tick();
        b_fv = 1'b0;
        checks++; if (b_count !== 3'd1 || b_occ !== 6'b100000 || b_err !== 1'b0) begin errors++; $display("[TB] FAIL b_flush_mid: got count=%0d occ=%b err=%0b expected 1 100000 0", b_count, b_occ, b_err); end
        tick();
        checks++; if (b_busy !== 1'b0 || b_count !== 3'd0 || b_occ !== 6'b0 || b_id !== 3'd0) begin errors++; $display("[TB] FAIL b_flush_exit: got busy=%0b count=%0d occ=%b id=%0d expected 0 0 000000 0", b_busy, b_count, b_occ, b_id); end
        b_fv = 1'b1; b_fid = 3'd7; tick();
        b_fv = 1'b0;
        checks++; if (b_err !== 1'b1 || b_count !== 3'd0) begin errors++; $display("[TB] FAIL b_range_err: got err=%0b count=%0d expected 1 0", b_err, b_count); end
    endtask

    task automatic test_random();
        int q_a[$];
        int q_b[$];
        int exp_a, exp_b;
        for (int c = 0; c < 600; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            a_av = ($urandom_range(0, 3) != 0);
            b_av = ($urandom_range(0, 3) != 0);
            a_fl = ($urandom_range(0, 39) == 0);
            b_fl = ($urandom_range(0, 39) == 0);
            a_fv = $urandom_range(0, 1);
            b_fv = $urandom_range(0, 1);
            q_a.delete(); q_b.delete();
            for (int i = 0; i < AW; i++) if (ma.occ[i]) q_a.push_back(i);
            for (int i = 0; i < BW; i++) if (mb.occ[i]) q_b.push_back(i);
            a_fid = (q_a.size() > 0 && $urandom_range(0, 3) != 0) ? 3'(q_a[$urandom_range(0, q_a.size() - 1)]) : 3'($urandom_range(0, 7));
            b_fid = (q_b.size() > 0 && $urandom_range(0, 3) != 0) ? 3'(q_b[$urandom_range(0, q_b.size() - 1)]) : 3'($urandom_range(0, 7));
            exp_a = m_pick(ma, AW);
            exp_b = m_pick(mb, BW);
            checks++; if (a_rdy !== (!ma.flush && exp_a >= 0) || (a_rdy === 1'b1 && a_id !== 3'(exp_a))) begin errors++; $display("[TB] FAIL rand_a_grant: cycle %0d got rdy=%0b id=%0d expected rdy=%0b id=%0d", c, a_rdy, a_id, !ma.flush && exp_a >= 0, exp_a); end
            checks++; if (b_rdy !== (!mb.flush && exp_b >= 0) || (b_rdy === 1'b1 && b_id !== 3'(exp_b))) begin errors++; $display("[TB] FAIL rand_b_grant: cycle %0d got rdy=%0b id=%0d expected rdy=%0b id=%0d", c, b_rdy, b_id, !mb.flush && exp_b >= 0, exp_b); end
            tick();
            checks++; if (a_occ !== m_vec(ma, AW) || a_count !== 4'(m_count(ma, AW)) || a_busy !== ma.flush || a_err !== ma.err || a_full !== (m_count(ma, AW) == AW) || a_empty !== (m_count(ma, AW) == 0)) begin errors++; $display("[TB] FAIL rand_a_state: cycle %0d got occ=%b count=%0d busy=%0b err=%0b expected occ=%b count=%0d busy=%0b err=%0b", c, a_occ, a_count, a_busy, a_err, m_vec(ma, AW), m_count(ma, AW), ma.flush, ma.err); end
            checks++; if (b_occ !== 6'(m_vec(mb, BW)) || b_count !== 3'(m_count(mb, BW)) || b_busy !== mb.flush || b_err !== mb.err || b_full !== (m_count(mb, BW) == BW) || b_empty !== (m_count(mb, BW) == 0)) begin errors++; $display("[TB] FAIL rand_b_state: cycle %0d got occ=%b count=%0d busy=%0b err=%0b expected occ=%b count=%0d busy=%0b err=%0b", c, b_occ, b_count, b_busy, b_err, 6'(m_vec(mb, BW)), m_count(mb, BW), mb.flush, mb.err); end
        end
        rst = 1'b0;
        a_av = 1'b0; a_fv = 1'b0; a_fl = 1'b0;
        b_av = 1'b0; b_fv = 1'b0; b_fl = 1'b0;
    endtask

    task automatic test_reset_clears_err();
        a_fv = 1'b1; a_fid = 3'd1; b_fv = 1'b1; b_fid = 3'd6; tick();
        a_fv = 1'b0; b_fv = 1'b0;
        rst = 1'b1; tick();
        rst = 1'b0;
        checks++; if (a_err !== 1'b0 || b_err !== 1'b0 || a_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_err_clear: got a_err=%0b b_err=%0b count=%0d expected 0 0 0", a_err, b_err, a_count); end
    endtask

    initial begin
        rst = 1'b1;
        a_av = 1'b0; a_fv = 1'b0; a_fl = 1'b0; a_fid = '0;
        b_av = 1'b0; b_fv = 1'b0; b_fl = 1'b0; b_fid = '0;
        ma = m_reset(); mb = m_reset();
        test_reset();
        test_fill();
        test_free_order();
        test_back_to_back();
        test_wrap();
        test_err();
        test_flush();
        test_nonpow2();
        test_reset();
        test_random();
        test_reset_clears_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
